hssi_lpbk_tester: RTL and testbench

HSSI_LPBK_TESTER -- requirements
Module: hssi_lpbk_tester

---
 rtl/hssi_lpbk_tester_if.sv | 28 ++
 rtl/hssi_lpbk_tester.sv | 82 ++++++++
 tb/tb_hssi_lpbk_tester.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hssi_lpbk_tester_if.sv
// hssi_lpbk_tester_if: control/status and HSSI lane bundle for the loopback tester
interface hssi_lpbk_tester_if #(
   parameter int NUM_LANES = 4,
   parameter int LANE_DW   = 64
);
   logic                         start;
   logic [31:0]                  num_words;
   logic                         link_ready;
   logic [NUM_LANES*LANE_DW-1:0] a2f_tx_parallel_data;
   logic [NUM_LANES*18-1:0]      a2f_tx_control;
   logic [NUM_LANES*LANE_DW-1:0] f2a_rx_parallel_data;
   logic [NUM_LANES*20-1:0]      f2a_rx_control;
   logic                         f2a_rx_enh_data_valid;
   logic                         busy;
   logic                         done;
   logic                         pass;
   logic [15:0]                  err_count;
   logic [31:0]                  first_err_idx;
   logic                         timeout;
   modport master (
      output start, num_words, link_ready, f2a_rx_parallel_data, f2a_rx_control, f2a_rx_enh_data_valid,
      input  a2f_tx_parallel_data, a2f_tx_control, busy, done, pass, err_count, first_err_idx, timeout
   );
   modport slave (
      input  start, num_words, link_ready, f2a_rx_parallel_data, f2a_rx_control, f2a_rx_enh_data_valid,
      output a2f_tx_parallel_data, a2f_tx_control, busy, done, pass, err_count, first_err_idx, timeout
   );
endinterface

// File: rtl/hssi_lpbk_tester.sv
// hssi_lpbk_tester: drives a sequence-numbered word stream on all lanes and checks the looped-back copy
module hssi_lpbk_tester #(
   parameter int NUM_LANES = 4,
   parameter int LANE_DW   = 64,
   parameter int TO_CYC    = 256
) (
   input logic pClk,
   input logic pck_cp2af_softReset,
   hssi_lpbk_tester_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WAIT_LINK, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [31:0] nw, tx_seq, rx_seq, to_cnt, first_idx;
   logic [15:0] err_cnt;
   logic armed, to_flag;
   logic [NUM_LANES-1:0] lane_bad;
   logic accept, active, idle_word, check, advance, bad, to_hit;
   assign accept    = bus.start && (state == IDLE || state == DONE);
   assign active    = state == RUN || state == DRAIN;
   assign idle_word = bus.f2a_rx_control[7:0] != 8'h00;
   // before arming only a non-idle word is looked at; after arming idle words are errors
   assign check     = active && bus.f2a_rx_enh_data_valid && (armed || !idle_word) && rx_seq != nw;
   assign advance   = check && !idle_word;
   assign bad       = check && |lane_bad;
   assign to_hit    = active && !advance && to_cnt + 32'd1 == 32'(TO_CYC);
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_bad[g] = bus.f2a_rx_parallel_data[g*LANE_DW +: LANE_DW] != LANE_DW'({8'(g), 24'h0, rx_seq})
                           || bus.f2a_rx_control[g*20 +: 20] != 20'h0;
      assign bus.a2f_tx_parallel_data[g*LANE_DW +: LANE_DW] =
         state == RUN ? LANE_DW'({8'(g), 24'h0, tx_seq}) : LANE_DW'(64'h0707070707070707);
      assign bus.a2f_tx_control[g*18 +: 18] = state == RUN ? 18'h0 : 18'h000FF;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (accept) state_nx = bus.num_words == 32'd0 ? DONE : WAIT_LINK;
         WAIT_LINK:  if (bus.link_ready) state_nx = RUN;
         RUN:        state_nx = to_hit ? DONE : tx_seq == nw - 32'd1 ? DRAIN : RUN;
         DRAIN:      state_nx = to_hit || rx_seq == nw ? DONE : DRAIN;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge pClk) begin
      if (pck_cp2af_softReset) begin
         state     <= IDLE;
         nw        <= '0;
         tx_seq    <= '0;
         rx_seq    <= '0;
         to_cnt    <= '0;
         first_idx <= '0;
         err_cnt   <= '0;
         armed     <= 1'b0;
         to_flag   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            nw        <= bus.num_words;
            tx_seq    <= '0;
            rx_seq    <= '0;
            to_cnt    <= '0;
            first_idx <= '0;
            err_cnt   <= '0;
            armed     <= 1'b0;
            to_flag   <= 1'b0;
         end else begin
            if (state == RUN) tx_seq <= tx_seq + 32'd1;
            if (check) armed <= 1'b1;
            if (advance) rx_seq <= rx_seq + 32'd1;
            if (active) to_cnt <= advance ? 32'd0 : to_cnt + 32'd1;
            if (to_hit) to_flag <= 1'b1;
            if (bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (bad && err_cnt == 16'd0) first_idx <= rx_seq;
         end
      end
   end
   assign bus.busy          = state == WAIT_LINK || active;
   assign bus.done          = state == DONE;
   assign bus.pass          = state == DONE && err_cnt == 16'd0 && !to_flag;
   assign bus.err_count     = err_cnt;
   assign bus.first_err_idx = first_idx;
   assign bus.timeout       = to_flag;
endmodule

// File: tb/tb_hssi_lpbk_tester.sv
// tb_hssi_lpbk_tester: queue-based loopback channel with latency, stalls and bit flips, scenario tasks
module tb_hssi_lpbk_tester;
   localparam int NL = 4, DW = 64, TO = 64, W = NL*DW;
   localparam logic [DW-1:0] IDLE_D = 64'h0707070707070707;
   typedef struct { logic [W-1:0] d; logic [NL*18-1:0] c; int ts; } ent_t;
   logic clk = 0, rst = 1;
   int checks = 0, errors = 0, cyc = 0;
   ent_t q[$];
   int lat, stall_pct, push_cnt, pop_cnt, tx_bad, run_cyc;
   bit cut;
   int flip[int];
   hssi_lpbk_tester_if #(.NUM_LANES(NL), .LANE_DW(DW)) bus ();
   hssi_lpbk_tester #(.NUM_LANES(NL), .LANE_DW(DW), .TO_CYC(TO)) dut (
      .pClk(clk), .pck_cp2af_softReset(rst), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [W-1:0] word_of(int unsigned s);
      logic [W-1:0] w;
      for (int p = 0; p < NL; p++) w[p*DW +: DW] = {8'(p), 24'h0, 32'(s)};
      return w;
   endfunction
   function automatic logic [NL*20-1:0] widen(logic [NL*18-1:0] c);
      logic [NL*20-1:0] r;
      for (int p = 0; p < NL; p++) r[p*20 +: 20] = {2'b0, c[p*18 +: 18]};
      return r;
   endfunction
   function automatic bit tx_idle();
      return bus.a2f_tx_parallel_data === {NL{IDLE_D}} && bus.a2f_tx_control === {NL{18'h000FF}};
   endfunction
   // loopback channel: tx words queue up and come back after lat cycles, optionally stalled or corrupted
   initial begin
      ent_t e;
      logic [W-1:0] d;
      bus.f2a_rx_parallel_data = {NL{IDLE_D}};
      bus.f2a_rx_control = {NL{20'h000FF}};
      bus.f2a_rx_enh_data_valid = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bus.a2f_tx_control[7:0] == 8'h00) begin
            if (run_cyc < 0) run_cyc = cyc;
            if (bus.a2f_tx_parallel_data !== word_of(push_cnt) || bus.a2f_tx_control !== '0) tx_bad++;
            e.d = bus.a2f_tx_parallel_data; e.c = bus.a2f_tx_control; e.ts = cyc;
            q.push_back(e);
            push_cnt++;
         end else if (!tx_idle()) tx_bad++;
         if (!cut && q.size() > 0 && cyc >= q[0].ts + lat) begin
            if ($urandom_range(0, 99) < stall_pct) begin
               bus.f2a_rx_enh_data_valid = 1'b0;
               bus.f2a_rx_parallel_data = {8{$urandom}};
            end else begin
               e = q.pop_front();
               d = e.d;
               if (flip.exists(pop_cnt)) d[flip[pop_cnt]] = ~d[flip[pop_cnt]];
               bus.f2a_rx_parallel_data = d;
               bus.f2a_rx_control = widen(e.c);
               bus.f2a_rx_enh_data_valid = 1'b1;
               pop_cnt++;
            end
         end else begin
            bus.f2a_rx_parallel_data = {NL{IDLE_D}};
            bus.f2a_rx_control = {NL{20'h000FF}};
            bus.f2a_rx_enh_data_valid = 1'b1;
         end
      end
   end
   task automatic clear_lb(int l, int sp, bit ct);
      q.delete(); flip.delete();
      lat = l; stall_pct = sp; cut = ct;
      push_cnt = 0; pop_cnt = 0; tx_bad = 0; run_cyc = -1;
   endtask
   task automatic launch(int unsigned n, output int sc);
      @(negedge clk);
      bus.start = 1'b1; bus.num_words = n; sc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic wait_done(int budget, output bit ok, output int dc);
      ok = 0; dc = 0;
      for (int i = 0; i < budget; i++) begin
         if (bus.done === 1'b1) begin ok = 1; dc = cyc; break; end
         @(negedge clk);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({bus.busy, bus.done, bus.pass, bus.timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.pass, bus.timeout}); end
      checks++; if (bus.err_count !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", bus.err_count); end
      checks++; if (bus.first_err_idx !== 32'd0) begin errors++; $display("FAIL reset_first: got %0d want 0", bus.first_err_idx); end
      checks++; if (!tx_idle()) begin errors++; $display("FAIL reset_tx: got %h want idle", bus.a2f_tx_parallel_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_zero_words();
      int sc, bad_cnt;
      clear_lb(0, 0, 0);
      launch(0, sc);
      checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin errors++; $display("FAIL zero_done: got done=%b pass=%b want 1 1", bus.done, bus.pass); end
      bad_cnt = 0;
      repeat (4) begin
         if (bus.busy !== 1'b0 || bus.done !== 1'b1) bad_cnt++;
         @(negedge clk);
      end
      checks++; if (bad_cnt != 0 || push_cnt != 0) begin errors++; $display("FAIL zero_busy: got %0d bad cycles %0d words want 0 0", bad_cnt, push_cnt); end
   endtask
   task automatic test_comb_loopback();
      int sc, dc; bit ok;
      clear_lb(0, 0, 0);
      bus.link_ready = 1'b1;
      launch(100, sc);
      wait_done(300, ok, dc);
      checks++; if (!ok) begin errors++; $display("FAIL comb_done: got no done want done"); end
      checks++; if (dc - sc < 101 || dc - sc > 103) begin errors++; $display("FAIL comb_latency: got %0d want 101..103", dc - sc); end
      checks++; if (bus.pass !== 1'b1 || bus.err_count !== 16'd0) begin errors++; $display("FAIL comb_pass: got pass=%b err=%0d want 1 0", bus.pass, bus.err_count); end
      checks++; if (push_cnt != 100 || tx_bad != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL comb_tx: got %0d words %0d bad busy=%b want 100 0 0", push_cnt, tx_bad, bus.busy); end
   endtask
   task automatic test_registered();
      int sc, dc; bit ok;
      clear_lb(3, 0, 0);
      launch(1000, sc);
      wait_done(1500, ok, dc);
      checks++; if (!ok || bus.pass !== 1'b1 || bus.err_count !== 16'd0) begin errors++; $display("FAIL reg_pass: got ok=%b pass=%b err=%0d want 1 1 0", ok, bus.pass, bus.err_count); end
      checks++; if (push_cnt != 1000 || tx_bad != 0 || !tx_idle()) begin errors++; $display("FAIL reg_tx: got %0d words %0d bad want 1000 0 then idle", push_cnt, tx_bad); end
   endtask
   task automatic test_errors();
      int sc, dc; bit ok;
      clear_lb(2, 0, 0);
      flip[10] = 2*DW + 5; flip[11] = 2*DW + 5;
      launch(50, sc);
      wait_done(300, ok, dc);
      checks++; if (!ok || bus.err_count !== 16'd2) begin errors++; $display("FAIL err_count: got %0d (done %b) want 2", bus.err_count, ok); end
      checks++; if (bus.first_err_idx !== 32'd10) begin errors++; $display("FAIL err_first: got %0d want 10", bus.first_err_idx); end
      checks++; if (bus.pass !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL err_pass: got pass=%b to=%b want 0 0", bus.pass, bus.timeout); end
   endtask
   task automatic test_cut();
      int sc, dc; bit ok;
      clear_lb(0, 0, 1);
      launch(8, sc);
      wait_done(TO + 50, ok, dc);
      checks++; if (!ok || bus.timeout !== 1'b1 || bus.pass !== 1'b0) begin errors++; $display("FAIL cut_timeout: got ok=%b to=%b pass=%b want 1 1 0", ok, bus.timeout, bus.pass); end
      checks++; if (dc - run_cyc < TO - 1 || dc - run_cyc > TO + 1) begin errors++; $display("FAIL cut_latency: got %0d want %0d..%0d", dc - run_cyc, TO - 1, TO + 1); end
      checks++; if (push_cnt != 8 || bus.err_count !== 16'd0) begin errors++; $display("FAIL cut_tx: got %0d words err=%0d want 8 0", push_cnt, bus.err_count); end
   endtask
   task automatic test_link_wait();
      int sc, dc, hold_bad; bit ok;
      clear_lb(1, 0, 0);
      bus.link_ready = 1'b0;
      launch(20, sc);
      hold_bad = 0;
      repeat (500) begin
         if (bus.busy !== 1'b1 || !tx_idle()) hold_bad++;
         @(negedge clk);
      end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL link_hold: got %0d bad cycles want 0", hold_bad); end
      bus.link_ready = 1'b1;
      wait_done(200, ok, dc);
      checks++; if (!ok || bus.pass !== 1'b1 || push_cnt != 20) begin errors++; $display("FAIL link_done: got ok=%b pass=%b words=%0d want 1 1 20", ok, bus.pass, push_cnt); end
   endtask
   task automatic test_back_to_back();
      int sc, dc; bit ok;
      clear_lb(1, 0, 0);
      flip[3] = 7;
      launch(10, sc);
      wait_done(100, ok, dc);
      checks++; if (!ok || bus.err_count !== 16'd1 || bus.first_err_idx !== 32'd3) begin errors++; $display("FAIL b2b_first: got err=%0d idx=%0d want 1 3", bus.err_count, bus.first_err_idx); end
      clear_lb(1, 0, 0);
      launch(10, sc);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.err_count !== 16'd0 || bus.first_err_idx !== 32'd0) begin errors++; $display("FAIL b2b_clear: got done=%b busy=%b err=%0d idx=%0d want 0 1 0 0", bus.done, bus.busy, bus.err_count, bus.first_err_idx); end
      wait_done(100, ok, dc);
      checks++; if (!ok || bus.pass !== 1'b1) begin errors++; $display("FAIL b2b_second: got ok=%b pass=%b want 1 1", ok, bus.pass); end
   endtask
   task automatic test_reset_mid();
      int sc, done_seen; bit found;
      clear_lb(1, 0, 0);
      flip[5] = 0;
      launch(100, sc);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.a2f_tx_control[7:0] === 8'h00 && bus.a2f_tx_parallel_data[31:0] === 32'd40) begin found = 1; break; end
         @(negedge clk);
      end
      checks++; if (!found) begin errors++; $display("FAIL mid_reach40: got not found want tx_seq 40"); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({bus.busy, bus.done, bus.pass, bus.timeout} !== 4'b0 || bus.err_count !== 16'd0 || bus.first_err_idx !== 32'd0) begin errors++; $display("FAIL mid_outputs: got flags=%b err=%0d idx=%0d want 0", {bus.busy, bus.done, bus.pass, bus.timeout}, bus.err_count, bus.first_err_idx); end
      checks++; if (!tx_idle()) begin errors++; $display("FAIL mid_tx: got %h want idle", bus.a2f_tx_parallel_data); end
      rst = 1'b0;
      done_seen = 0;
      repeat (30) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
         @(negedge clk);
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL mid_nodone: got %0d active cycles want 0", done_seen); end
   endtask
   task automatic test_random();
      int sc, dc, n, k, exp_err, exp_first; bit ok;
      for (int it = 0; it < 12; it++) begin
         n = $urandom_range(1, 300);
         clear_lb($urandom_range(0, 6), $urandom_range(0, 1) ? 20 : 0, 0);
         k = $urandom_range(0, 3);
         for (int j = 0; j < k; j++) flip[$urandom_range(0, n - 1)] = $urandom_range(0, W - 1);
         exp_err = flip.num();
         exp_first = 0;
         if (exp_err > 0) void'(flip.first(exp_first));
         bus.link_ready = 1'b0;
         launch(n, sc);
         bus.start = 1'b1; bus.num_words = n + 5;
         @(negedge clk);
         bus.start = 1'b0;
         repeat ($urandom_range(0, 5)) @(negedge clk);
         bus.link_ready = 1'b1;
         wait_done(n * 3 + 200, ok, dc);
         checks++; if (!ok || bus.err_count !== 16'(exp_err) || bus.timeout !== 1'b0) begin errors++; $display("FAIL rnd%0d_err: got ok=%b err=%0d to=%b want 1 %0d 0", it, ok, bus.err_count, bus.timeout, exp_err); end
         checks++; if (bus.first_err_idx !== 32'(exp_first) || bus.pass !== (exp_err == 0)) begin errors++; $display("FAIL rnd%0d_first: got idx=%0d pass=%b want %0d %b", it, bus.first_err_idx, bus.pass, exp_first, exp_err == 0); end
         checks++; if (push_cnt != n || tx_bad != 0) begin errors++; $display("FAIL rnd%0d_tx: got %0d words %0d bad want %0d 0", it, push_cnt, tx_bad, n); end
      end
   endtask
   initial begin
      bus.start = 1'b0; bus.num_words = '0; bus.link_ready = 1'b1;
      clear_lb(0, 0, 0);
      test_reset();
      test_zero_words();
      test_comb_loopback();
      test_registered();
      test_errors();
      test_cut();
      test_link_wait();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
